// File: rtl/risc_bus_testdev.sv
// Memory-mapped test device for the risc_cpu bus: exit-code/halt register,
// buffered console TX FIFO, free-running cycle counter and optional watchdog.
module risc_bus_testdev #(
   parameter int                ADDR_W       = 8,
   parameter int                DATA_W       = 8,
   parameter logic [ADDR_W-1:0] HALT_ADDR    = 'hAB,
   parameter logic [ADDR_W-1:0] CONSOLE_ADDR = 'hAA,
   parameter logic [ADDR_W-1:0] STATUS_ADDR  = 'hA9,
   parameter logic [ADDR_W-1:0] CYCLE_ADDR   = 'hA8,
   parameter int                FIFO_DEPTH   = 4,
   parameter int                TIMEOUT      = 0,
   parameter int                CNT_W        = 32
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic [ADDR_W-1:0] i_bus_address,
   input  logic [DATA_W-1:0] i_bus_data,
   input  logic              i_bus_read,
   input  logic              i_bus_write,
   output logic [DATA_W-1:0] o_bus_data,
   output logic              o_bus_rvalid,
   output logic [DATA_W-1:0] o_tx_data,
   output logic              o_tx_valid,
   input  logic              i_tx_ready,
   output logic              o_halted,
   output logic              o_timeout,
   output logic [DATA_W-1:0] o_exit_code
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT - 1);

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr_reg;
   logic [PTR_W:0]    rd_ptr_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              halted_reg;
   logic              timeout_reg;
   logic              overflow_reg;
   logic              rvalid_reg;
   logic [DATA_W-1:0] exit_code_reg;
   logic [DATA_W-1:0] bus_data_reg;

   logic              fifo_empty;
   logic              fifo_full;
   logic              wr_halt;
   logic              wr_console;
   logic              rd_status;
   logic              wd_fire;
   logic              pop;
   logic              push;
   logic              ovf_event;
   logic [3:0]        status4;
   logic [DATA_W-1:0] status_word;
   logic [DATA_W-1:0] rd_value;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                       (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

   assign wr_halt    = i_bus_write && (i_bus_address == HALT_ADDR) && !halted_reg;
   assign wr_console = i_bus_write && (i_bus_address == CONSOLE_ADDR);
   assign rd_status  = i_bus_read && (i_bus_address == STATUS_ADDR);
   assign wd_fire    = (TIMEOUT != 0) && !halted_reg && (cnt_reg == WD_LIMIT);

   assign pop        = !fifo_empty && i_tx_ready;
   assign push       = wr_console && (!fifo_full || pop);
   assign ovf_event  = wr_console && fifo_full && !pop;

   assign status4 = {halted_reg, overflow_reg, fifo_empty, fifo_full};

   generate
      if (DATA_W >= 4) begin : g_status_wide
         assign status_word = DATA_W'(status4);
      end else begin : g_status_narrow
         assign status_word = DATA_W'(status4[2:0]);
      end
   endgenerate

   always_comb begin
      rd_value = '0;
      if (i_bus_address == CYCLE_ADDR) begin
         rd_value = DATA_W'(cnt_reg);
      end else if (i_bus_address == STATUS_ADDR) begin
         rd_value = status_word;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= i_bus_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         cnt_reg       <= '0;
         halted_reg    <= 1'b0;
         timeout_reg   <= 1'b0;
         overflow_reg  <= 1'b0;
         rvalid_reg    <= 1'b0;
         exit_code_reg <= '0;
         bus_data_reg  <= '0;
      end else begin
         // The counter stops on the halting edge so it reports cycles run before the halt.
         if (!halted_reg && !wr_halt && !wd_fire) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (wr_halt) begin
            halted_reg    <= 1'b1;
            exit_code_reg <= i_bus_data;
         end else if (wd_fire) begin
            halted_reg    <= 1'b1;
            timeout_reg   <= 1'b1;
            exit_code_reg <= '1;
         end
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (ovf_event) begin
            overflow_reg <= 1'b1;
         end else if (rd_status) begin
            overflow_reg <= 1'b0;
         end
         rvalid_reg <= i_bus_read;
         if (i_bus_read) begin
            bus_data_reg <= rd_value;
         end
      end
   end

   assign o_bus_data   = bus_data_reg;
   assign o_bus_rvalid = rvalid_reg;
   assign o_tx_valid   = !fifo_empty;
   assign o_tx_data    = fifo_empty ? '0 : fifo_mem[rd_ptr_reg[PTR_W-1:0]];
   assign o_halted     = halted_reg;
   assign o_timeout    = timeout_reg;
   assign o_exit_code  = exit_code_reg;

endmodule

// File: tb/tb_risc_bus_testdev.sv
// Scoreboard bench for risc_bus_testdev: read and TX responses are queued at
// issue time and checked by independent monitors.
module tb_risc_bus_testdev;

   logic       i_clk = 1'b0;
   logic       i_rstn = 1'b0;
   logic [7:0] i_bus_address = '0;
   logic [7:0] i_bus_data = '0;
   logic       i_bus_read = 1'b0;
   logic       i_bus_write = 1'b0;
   logic [7:0] o_bus_data;
   logic       o_bus_rvalid;
   logic [7:0] o_tx_data;
   logic       o_tx_valid;
   logic       i_tx_ready = 1'b0;
   logic       o_halted;
   logic       o_timeout;
   logic [7:0] o_exit_code;

   int tests = 0;
   int fails = 0;

   logic [7:0] rd_q[$];
   logic [7:0] tx_q[$];

   localparam logic [7:0] HALT = 8'hAB;
   localparam logic [7:0] CONS = 8'hAA;
   localparam logic [7:0] STAT = 8'hA9;
   localparam logic [7:0] CYC  = 8'hA8;

   risc_bus_testdev #(.TIMEOUT(20)) dut (
      .i_clk         (i_clk),
      .i_rstn        (i_rstn),
      .i_bus_address (i_bus_address),
      .i_bus_data    (i_bus_data),
      .i_bus_read    (i_bus_read),
      .i_bus_write   (i_bus_write),
      .o_bus_data    (o_bus_data),
      .o_bus_rvalid  (o_bus_rvalid),
      .o_tx_data     (o_tx_data),
      .o_tx_valid    (o_tx_valid),
      .i_tx_ready    (i_tx_ready),
      .o_halted      (o_halted),
      .o_timeout     (o_timeout),
      .o_exit_code   (o_exit_code)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("[TB] ok %s = %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rstn = 1'b0;
      tick();
      i_rstn = 1'b1;
   endtask

   task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
      i_bus_address = addr;
      i_bus_data    = data;
      i_bus_write   = 1'b1;
      tick();
      i_bus_write   = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] addr, input logic [7:0] exp);
      rd_q.push_back(exp);
      i_bus_address = addr;
      i_bus_read    = 1'b1;
      tick();
      i_bus_read    = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " halted"},   int'(o_halted), 0);
      check({tag, " timeout"},  int'(o_timeout), 0);
      check({tag, " exit"},     int'(o_exit_code), 0);
      check({tag, " tx_valid"}, int'(o_tx_valid), 0);
      check({tag, " tx_data"},  int'(o_tx_data), 0);
      check({tag, " rvalid"},   int'(o_bus_rvalid), 0);
      check({tag, " bus_data"}, int'(o_bus_data), 0);
   endtask

   // Read-response monitor
   always @(negedge i_clk) begin
      if (o_bus_rvalid) begin
         if (rd_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL read_unexpected: got %0h expected none", o_bus_data);
         end else begin
            check("read_data", int'(o_bus_data), int'(rd_q.pop_front()));
         end
      end
   end

   // TX monitor: a byte is consumed on every edge where valid & ready hold.
   always @(negedge i_clk) begin
      if (o_tx_valid && i_tx_ready) begin
         if (tx_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tx_unexpected: got %0h expected none", o_tx_data);
         end else begin
            check("tx_data", int'(o_tx_data), int'(tx_q.pop_front()));
         end
      end
   end

   initial begin
      // Halt register: first write wins
      do_reset();
      check_all_zero("reset");
      bus_write(HALT, 8'h5A);
      check("halt halted", int'(o_halted), 1);
      check("halt exit", int'(o_exit_code), 'h5A);
      check("halt timeout", int'(o_timeout), 0);
      bus_write(HALT, 8'h00);
      check("halt second write", int'(o_exit_code), 'h5A);

      // Console fill, overflow, clear-on-read, drain
      do_reset();
      i_tx_ready = 1'b0;
      bus_write(CONS, 8'h41);
      check("tx_valid after first push", int'(o_tx_valid), 1);
      bus_write(CONS, 8'h42);
      bus_write(CONS, 8'h43);
      bus_write(CONS, 8'h44);
      bus_write(CONS, 8'h45);
      bus_read(STAT, 8'b0101);
      bus_read(STAT, 8'b0001);
      tx_q.push_back(8'h41);
      tx_q.push_back(8'h42);
      tx_q.push_back(8'h43);
      tx_q.push_back(8'h44);
      i_tx_ready = 1'b1;
      repeat (6) tick();
      check("drain tx_valid", int'(o_tx_valid), 0);
      bus_read(STAT, 8'b0010);
      i_tx_ready = 1'b0;

      // Full FIFO with push and pop on the same edge
      do_reset();
      bus_write(CONS, 8'h11);
      bus_write(CONS, 8'h22);
      bus_write(CONS, 8'h33);
      bus_write(CONS, 8'h44);
      tx_q.push_back(8'h11);
      i_tx_ready = 1'b1;
      bus_write(CONS, 8'h55);
      i_tx_ready = 1'b0;
      bus_read(STAT, 8'b0001);
      tx_q.push_back(8'h22);
      tx_q.push_back(8'h33);
      tx_q.push_back(8'h44);
      tx_q.push_back(8'h55);
      i_tx_ready = 1'b1;
      repeat (6) tick();
      check("pushpop drained", int'(o_tx_valid), 0);
      i_tx_ready = 1'b0;

      // Watchdog fires exactly 20 edges after reset release
      do_reset();
      repeat (19) tick();
      check("wd not yet halted", int'(o_halted), 0);
      tick();
      check("wd halted", int'(o_halted), 1);
      check("wd timeout", int'(o_timeout), 1);
      check("wd exit", int'(o_exit_code), 'hFF);
      bus_read(CYC, 8'd19);

      // Halt write on the watchdog edge wins
      do_reset();
      repeat (19) tick();
      bus_write(HALT, 8'h07);
      check("race halted", int'(o_halted), 1);
      check("race exit", int'(o_exit_code), 'h07);
      check("race timeout", int'(o_timeout), 0);

      // Cycle read latency, then reset mid-run
      do_reset();
      tick();
      tick();
      bus_read(CYC, 8'd2);
      check("rvalid pulse", int'(o_bus_rvalid), 1);
      tick();
      check("rvalid one cycle", int'(o_bus_rvalid), 0);
      bus_write(CONS, 8'h66);
      bus_write(HALT, 8'h12);
      i_rstn = 1'b0;
      tick();
      check_all_zero("midrun reset");
      i_rstn = 1'b1;
      repeat (2) tick();

      tests++;
      if (rd_q.size() != 0 || tx_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0",
                  rd_q.size(), tx_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/risc_bus_testdev.md
Name: risc_bus_testdev

Overview:
Synthesizable memory-mapped test device on the risc_cpu 8-bit-style bus. It generalises the simulation "stop on write to 0xAB" convention into a parametrised peripheral with four functions: a halt/exit-code register, a buffered console TX channel, a free-running cycle counter and a watchdog timeout. It sits on the CPU bus alongside memory. Benches and FPGA builds observe o_halted / o_exit_code instead of decoding bus writes themselves.

Parameters:
ADDR_W, 8, bus address width
DATA_W, 8, bus data width (>=3)
HALT_ADDR, 'hAB, write-only exit-code register
CONSOLE_ADDR, 'hAA, write-only console TX register
STATUS_ADDR, 'hA9, read status register
CYCLE_ADDR, 'hA8, read low DATA_W bits of cycle counter
FIFO_DEPTH, 4, console FIFO entries (power of 2, >=2)
TIMEOUT, 0, watchdog limit in cycles; 0 disables
CNT_W, 32, cycle counter width

Ports:
i_clk  in  1  clock
i_rstn  in  1  synchronous active-low reset
i_bus_address  in  ADDR_W  CPU bus address
i_bus_data  in  DATA_W  CPU write data
i_bus_read  in  1  read strobe, one cycle
i_bus_write  in  1  write strobe, one cycle
o_bus_data  out  DATA_W  read data, registered
o_bus_rvalid  out  1  o_bus_data valid, one cycle
o_tx_data  out  DATA_W  console head byte
o_tx_valid  out  1  FIFO non-empty
i_tx_ready  in  1  sink accepts head when valid
o_halted  out  1  sticky halt flag
o_timeout  out  1  sticky: halt caused by watchdog
o_exit_code  out  DATA_W  captured exit code

Behaviour:
- Reset: one clock, synchronous, active-low, on i_clk. While i_rstn=0 at a rising edge, all outputs go to 0, the FIFO empties, the counter is 0 and overflow is cleared. Reset mid-operation discards FIFO contents and the halt state.
- Cycle counter: increments by 1 each cycle while o_halted=0. Frozen once halted. Wraps at 2^CNT_W.
- Halt write: i_bus_write with address HALT_ADDR while not halted. Next edge sets o_exit_code=i_bus_data and o_halted=1.
  - First halt wins; later halt writes are ignored.
- Watchdog: TIMEOUT!=0, not halted, counter==TIMEOUT-1 at an edge. That edge sets o_halted=1, o_timeout=1 and o_exit_code=all ones.
  - If a halt write lands in the same cycle, the write wins and o_timeout stays 0.
- Console write: i_bus_write to CONSOLE_ADDR pushes i_bus_data. Pushing is permitted while halted.
  - Full with no pop in the same cycle: data is dropped and sticky overflow is set.
  - Full with a pop (o_tx_valid & i_tx_ready) in the same cycle: push is accepted and occupancy is unchanged.
  - No bypass: a push to an empty FIFO raises o_tx_valid on the following cycle.
- TX handshake: o_tx_data is the FIFO head. Pop occurs when o_tx_valid & i_tx_ready. o_tx_data is stable while valid and not ready.
- Reads: i_bus_read sets o_bus_rvalid=1 for exactly one cycle, on the cycle after the strobe.
  - o_bus_data is registered and holds its last value otherwise.
  - CYCLE_ADDR returns counter[DATA_W-1:0] sampled at the strobe edge.
  - STATUS_ADDR returns bit0=full, bit1=empty, bit2=overflow, bit3=o_halted (bit3 only if DATA_W>=4); other bits 0.
  - Reading STATUS clears overflow on the same edge. If an overflow event occurs on that same edge, overflow stays set.
  - Unmapped addresses, HALT_ADDR and CONSOLE_ADDR read as 0.
- Simultaneous read and write: the write takes effect; the read returns the pre-edge state.
- Writes to unmapped addresses are ignored. Strobes are not qualified by o_halted, except for halt and watchdog capture.

Test Plan:
- Reset then write 8'h5A to HALT_ADDR -> o_halted=1 and o_exit_code=8'h5A one edge later, o_timeout=0; a second write of 8'h00 leaves 8'h5A.
- Console: i_tx_ready=0, write 'h41,'h42,'h43,'h44,'h45 -> first four stored, STATUS read = 'b0101 (full, overflow); next STATUS read = 'b0001; raise ready -> o_tx_data sequence 41,42,43,44, then o_tx_valid=0.
- Full FIFO plus push and pop in the same cycle -> no overflow, occupancy stays 4, new byte emitted last.
- TIMEOUT=20, no halt write -> o_halted=1, o_timeout=1, o_exit_code='hFF exactly 20 cycles after reset release; CYCLE read afterward returns 19.
- TIMEOUT=20, halt write of 'h07 on the watchdog cycle -> exit code 'h07, o_timeout=0.
- Read CYCLE_ADDR at the 3rd cycle after reset release -> o_bus_rvalid pulses one cycle later with value 2; assert i_rstn=0 mid-run -> all outputs 0 at the next edge.
